// File: rtl/spawn_ctrl_pkg.sv
// Shared definitions for the piece-sequencing stage: piece type codes, FSM
// state codes and gravity timing defaults.
package spawn_ctrl_pkg;

  localparam logic [2:0] TYPE1 = 3'd1;
  localparam logic [2:0] TYPE2 = 3'd2;
  localparam logic [2:0] TYPE3 = 3'd3;
  localparam logic [2:0] TYPE4 = 3'd4;
  localparam logic [2:0] TYPE5 = 3'd5;
  localparam logic [2:0] TYPE6 = 3'd6;
  localparam logic [2:0] TYPE7 = 3'd7;

  typedef logic [2:0] spawn_state_t;

  localparam logic [2:0] SPAWN_IDLE  = 3'd0;
  localparam logic [2:0] SPAWN_LOAD  = 3'd1;
  localparam logic [2:0] SPAWN_CHECK = 3'd2;
  localparam logic [2:0] SPAWN_PLAY  = 3'd3;
  localparam logic [2:0] SPAWN_OVER  = 3'd4;

  localparam int unsigned DROP_PERIOD_DEFAULT = 32'd12500000;
  localparam int unsigned SOFT_DIV_DEFAULT    = 32'd8;

  // Last counter value before a tick for a period of period/div cycles.
  function automatic int unsigned tick_limit(input int unsigned period, input int unsigned div);
    int unsigned cycles;
    cycles = period / div;
    if (cycles > 32'd0) begin
      return cycles - 32'd1;
    end else begin
      return 32'd0;
    end
  endfunction

endpackage

// File: rtl/spawn_ctrl_drop_timer.sv
// Gravity timer: counts cycles while the piece falls and emits a registered
// one-cycle drop_tick each time the (normal or soft-drop) threshold is met.
module drop_timer
  import spawn_ctrl_pkg::*;
#(
  parameter int unsigned DROP_PERIOD = DROP_PERIOD_DEFAULT,
  parameter int unsigned SOFT_DIV    = SOFT_DIV_DEFAULT
) (
  input  logic CLK_25M,
  input  logic key_reset,
  input  logic enable,
  input  logic clear,
  input  logic soft_drop,
  output logic drop_tick
);

  localparam int unsigned CNT_W = (DROP_PERIOD > 32'd1) ? $clog2(DROP_PERIOD) : 32'd1;
  localparam logic [CNT_W-1:0] LIMIT_NORM = CNT_W'(tick_limit(DROP_PERIOD, 32'd1));
  localparam logic [CNT_W-1:0] LIMIT_SOFT = CNT_W'(tick_limit(DROP_PERIOD, SOFT_DIV));

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] limit_s;
  logic             tick_r;

  // Select the active threshold from the soft-drop level.
  always_comb begin
    limit_s = LIMIT_NORM;
    if (soft_drop) begin
      limit_s = LIMIT_SOFT;
    end else begin
      limit_s = LIMIT_NORM;
    end
  end

  // Counter and tick register; >= catches a switch to soft drop past the small limit.
  always_ff @(posedge CLK_25M or posedge key_reset) begin
    if (key_reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else if (!enable || clear) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r >= limit_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      tick_r <= 1'b0;
    end
  end

  assign drop_tick = tick_r;

endmodule

// File: rtl/spawn_ctrl.sv
// Piece-sequencing FSM: latches the next piece, runs the spawn-collision
// handshake with the board, drives gravity and flags game over.
module spawn_ctrl
  import spawn_ctrl_pkg::*;
#(
  parameter int unsigned DROP_PERIOD = DROP_PERIOD_DEFAULT,
  parameter int unsigned SOFT_DIV    = SOFT_DIV_DEFAULT,
  parameter int unsigned TYPE_W      = 32'd3
) (
  input  logic              CLK_25M,
  input  logic              key_reset,
  input  logic              key_start,
  input  logic [TYPE_W-1:0] next_type,
  input  logic              piece_locked,
  input  logic              check_ack,
  input  logic              spawn_blocked,
  input  logic              soft_drop,
  output logic              Update,
  output logic [TYPE_W-1:0] cur_type,
  output logic              spawn_req,
  output logic              spawn_valid,
  output logic              drop_tick,
  output logic              playing,
  output logic              game_over
);

  spawn_state_t      state_r;
  spawn_state_t      state_nxt_s;
  logic [TYPE_W-1:0] cur_type_r;
  logic              update_r;
  logic              spawn_req_r;
  logic              spawn_valid_r;
  logic              playing_r;
  logic              game_over_r;
  logic              timer_en_s;
  logic              timer_clr_s;

  // Next-state decode; OVER is only left through reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SPAWN_IDLE: begin
        if (key_start) begin
          state_nxt_s = SPAWN_LOAD;
        end else begin
          state_nxt_s = SPAWN_IDLE;
        end
      end
      SPAWN_LOAD: state_nxt_s = SPAWN_CHECK;
      SPAWN_CHECK: begin
        if (check_ack && spawn_blocked) begin
          state_nxt_s = SPAWN_OVER;
        end else if (check_ack) begin
          state_nxt_s = SPAWN_PLAY;
        end else begin
          state_nxt_s = SPAWN_CHECK;
        end
      end
      SPAWN_PLAY: begin
        if (piece_locked) begin
          state_nxt_s = SPAWN_LOAD;
        end else begin
          state_nxt_s = SPAWN_PLAY;
        end
      end
      SPAWN_OVER: state_nxt_s = SPAWN_OVER;
      default:    state_nxt_s = SPAWN_IDLE;
    endcase
  end

  // State register with outputs registered from the next state so they align with it.
  always_ff @(posedge CLK_25M or posedge key_reset) begin
    if (key_reset) begin
      state_r       <= SPAWN_IDLE;
      update_r      <= 1'b0;
      spawn_req_r   <= 1'b0;
      spawn_valid_r <= 1'b0;
      playing_r     <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      update_r      <= (state_nxt_s == SPAWN_LOAD);
      spawn_req_r   <= (state_nxt_s == SPAWN_CHECK);
      spawn_valid_r <= (state_r == SPAWN_CHECK) && check_ack && !spawn_blocked;
      playing_r     <= (state_nxt_s == SPAWN_CHECK) || (state_nxt_s == SPAWN_PLAY);
      game_over_r   <= (state_nxt_s == SPAWN_OVER);
    end
  end

  // Capture the pre-advance generator output at the end of LOAD; zero falls back to TYPE1.
  always_ff @(posedge CLK_25M or posedge key_reset) begin
    if (key_reset) begin
      cur_type_r <= {TYPE_W{1'b0}};
    end else if (state_r == SPAWN_LOAD) begin
      if (next_type == {TYPE_W{1'b0}}) begin
        cur_type_r <= TYPE_W'(TYPE1);
      end else begin
        cur_type_r <= next_type;
      end
    end else begin
      cur_type_r <= cur_type_r;
    end
  end

  assign timer_en_s  = (state_r == SPAWN_PLAY);
  assign timer_clr_s = piece_locked;

  drop_timer #(
    .DROP_PERIOD (DROP_PERIOD),
    .SOFT_DIV    (SOFT_DIV)
  ) u_drop_timer (
    .CLK_25M   (CLK_25M),
    .key_reset (key_reset),
    .enable    (timer_en_s),
    .clear     (timer_clr_s),
    .soft_drop (soft_drop),
    .drop_tick (drop_tick)
  );

  assign Update      = update_r;
  assign cur_type    = cur_type_r;
  assign spawn_req   = spawn_req_r;
  assign spawn_valid = spawn_valid_r;
  assign playing     = playing_r;
  assign game_over   = game_over_r;

endmodule

// File: tb/tb_spawn_ctrl.sv
// Directed bench for spawn_ctrl: a vector table walks start, handshake,
// gravity and game over; short sequences cover asynchronous resets.
module tb_spawn_ctrl;

  logic       CLK_25M = 1'b0;
  logic       key_reset;
  logic       key_start;
  logic [2:0] next_type;
  logic       piece_locked;
  logic       check_ack;
  logic       spawn_blocked;
  logic       soft_drop;
  logic       Update;
  logic [2:0] cur_type;
  logic       spawn_req;
  logic       spawn_valid;
  logic       drop_tick;
  logic       playing;
  logic       game_over;
  logic [8:0] obs_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         rep;
    logic       ks;
    logic [2:0] nt;
    logic       pl;
    logic       ack;
    logic       blk;
    logic       sd;
    logic [8:0] exp;
  } vec_t;

  vec_t vq[$];

  spawn_ctrl #(
    .DROP_PERIOD (16),
    .SOFT_DIV    (8),
    .TYPE_W      (3)
  ) dut (
    .CLK_25M       (CLK_25M),
    .key_reset     (key_reset),
    .key_start     (key_start),
    .next_type     (next_type),
    .piece_locked  (piece_locked),
    .check_ack     (check_ack),
    .spawn_blocked (spawn_blocked),
    .soft_drop     (soft_drop),
    .Update        (Update),
    .cur_type      (cur_type),
    .spawn_req     (spawn_req),
    .spawn_valid   (spawn_valid),
    .drop_tick     (drop_tick),
    .playing       (playing),
    .game_over     (game_over)
  );

  always #20 CLK_25M = ~CLK_25M;

  // Observed bus: {Update, cur_type, spawn_req, spawn_valid, drop_tick, playing, game_over}
  assign obs_s = {Update, cur_type, spawn_req, spawn_valid, drop_tick, playing, game_over};

  function automatic logic [8:0] ex(input logic upd, input logic [2:0] ct, input logic [4:0] rest);
    return {upd, ct, rest};
  endfunction

  task automatic add(input int rep, input logic ks, input logic [2:0] nt, input logic pl,
                     input logic ack, input logic blk, input logic sd, input logic [8:0] e);
    vec_t v;
    v.rep = rep; v.ks = ks; v.nt = nt; v.pl = pl;
    v.ack = ack; v.blk = blk; v.sd = sd; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic drive(input logic ks, input logic [2:0] nt, input logic pl,
                       input logic ack, input logic blk, input logic sd);
    key_start = ks; next_type = nt; piece_locked = pl;
    check_ack = ack; spawn_blocked = blk; soft_drop = sd;
  endtask

  task automatic step();
    @(posedge CLK_25M);
    #1;
  endtask

  task automatic chk(input string nm, input logic [8:0] e);
    total++;
    if (obs_s !== e) begin
      bad++;
      $display("FAIL %s: got upd/type/req/val/tick/play/over=%b want %b (t=%0t)", nm, obs_s, e, $time);
    end
  endtask

  task automatic async_reset(input string nm);
    #5 key_reset = 1'b1;
    #2 chk(nm, 9'd0);
    @(negedge CLK_25M);
    key_reset = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // rest bits: {spawn_req, spawn_valid, drop_tick, playing, game_over}
    add(1,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd0, 5'b00000));
    add(1,  1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, 3'd0, 5'b00000));
    add(1,  1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b10010));
    add(9,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b10010));
    add(1,  1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b01010));
    add(15, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b00010));
    add(1,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b00110));
    add(15, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b00010));
    add(1,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b00110));
    add(1,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 3'd5, 5'b00010));
    add(1,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 3'd5, 5'b00110));
    add(1,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 3'd5, 5'b00010));
    add(1,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 3'd5, 5'b00110));
    add(5,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b00010));
    add(1,  1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 3'd5, 5'b00110));
    add(15, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd5, 5'b00010));
    add(1,  1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, 3'd5, 5'b00000));
    add(1,  1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 3'd3, 5'b10010));
    add(1,  1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 3'd3, 5'b00001));
    add(3,  1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, ex(1'b0, 3'd3, 5'b00001));

    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    key_reset = 1'b1;
    step();
    step();
    chk("reset_state", 9'd0);
    @(negedge CLK_25M);
    key_reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ks, vq[i].nt, vq[i].pl, vq[i].ack, vq[i].blk, vq[i].sd);
      for (int r = 0; r < vq[i].rep; r++) begin
        step();
        chk($sformatf("vec%0d.%0d", i, r), vq[i].exp);
      end
    end

    async_reset("rst_over");

    // Zero type falls back to TYPE1; held start and stray lock are ignored in CHECK.
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("load_zero", ex(1'b1, 3'd0, 5'b00000));
    drive(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("fallback_type1", ex(1'b0, 3'd1, 5'b10010));
    step();
    chk("check_hold", ex(1'b0, 3'd1, 5'b10010));
    async_reset("rst_check");

    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("restart_load", ex(1'b1, 3'd0, 5'b00000));
    drive(1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("restart_check", ex(1'b0, 3'd7, 5'b10010));
    drive(1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("restart_play", ex(1'b0, 3'd7, 5'b01010));
    drive(1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("play_ignore%0d", k), ex(1'b0, 3'd7, 5'b00010));
    end
    async_reset("rst_play");

    step();
    chk("idle_after", 9'd0);
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("restart_again", ex(1'b1, 3'd0, 5'b00000));
    drive(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("restart_type4", ex(1'b0, 3'd4, 5'b10010));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spawn_ctrl.md
Name: spawn_ctrl

Overview:
- Piece-sequencing stage directly downstream of the next-piece generator.
- Consumes `next_type`, latches it as the current falling piece, and returns a one-cycle `Update` pulse so the generator advances its sequence.
- Runs a spawn-collision handshake with the board logic, generates gravity `drop_tick` pulses while a piece is falling, and declares game over when a spawn is blocked.

Parameters:
- DROP_PERIOD, 12500000: `CLK_25M` cycles between gravity ticks (0.5 s).
- SOFT_DIV, 8: divisor applied to DROP_PERIOD while `soft_drop` is held; must be a power of two.
- TYPE_W, 3: width of a piece type code.

Ports:
- CLK_25M  in  1  system clock, 25 MHz.
- key_reset  in  1  asynchronous, active-high reset.
- key_start  in  1  start request, level or pulse.
- next_type  in  TYPE_W  upcoming piece from the generator; legal values 1..7.
- piece_locked  in  1  one-cycle pulse from the board when the active piece has landed.
- check_ack  in  1  board response strobe for a spawn check.
- spawn_blocked  in  1  collision result; valid only while `check_ack`=1.
- soft_drop  in  1  player holds down.
- Update  out  1  one-cycle advance pulse to the generator.
- cur_type  out  TYPE_W  type of the active piece.
- spawn_req  out  1  spawn-check request to the board.
- spawn_valid  out  1  one-cycle pulse: piece placed at spawn position.
- drop_tick  out  1  one-cycle gravity pulse.
- playing  out  1  high in CHECK and PLAY.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (asynchronous, any cycle, including mid-handshake):
  - state=IDLE.
  - `Update`, `spawn_req`, `spawn_valid`, `drop_tick`, `playing`, `game_over` = 0.
  - `cur_type`=0; drop counter=0.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- IDLE:
  - `key_start`=1 at an edge -> LOAD.
- LOAD (exactly 1 cycle):
  - `Update`=1 for this cycle only.
  - At the edge ending LOAD, `cur_type` <= `next_type`. This captures the pre-advance value, since the generator advances on the same edge.
  - If `next_type`==0, `cur_type` <= 1 (TYPE1 fallback).
  - Next state: CHECK.
- CHECK:
  - `spawn_req`=1 continuously until an edge where `check_ack`=1.
  - On ack with `spawn_blocked`=1 -> OVER.
  - On ack with `spawn_blocked`=0 -> PLAY, with `spawn_valid`=1 for the first PLAY cycle.
  - No timeout; `check_ack` while not in CHECK is ignored.
- PLAY:
  - Counter increments by 1 each cycle.
  - Threshold T = DROP_PERIOD-1, or DROP_PERIOD/SOFT_DIV-1 while `soft_drop`=1.
  - When counter >= T: counter <= 0 and `drop_tick`=1 on the following cycle. This covers switching to soft drop with the counter already past the small threshold: the tick comes on the next cycle.
  - `piece_locked`=1 has priority over tick generation:
    - state <= LOAD and counter <= 0;
    - no `drop_tick` is issued from that cycle's threshold match.
  - `key_start` is ignored in PLAY.
- OVER:
  - `game_over`=1, `playing`=0.
  - `cur_type` holds.
  - All inputs except `key_reset` are ignored; only reset leaves OVER.
- Counter width is clog2(DROP_PERIOD). It never exceeds T and wraps only via the clear.
- Simultaneous events:
  - `piece_locked` while not in PLAY is ignored.
  - `key_start` held through LOAD/CHECK has no effect.
  - `Update` is never asserted twice without an intervening CHECK.

Decomposition:
- Shared header (global.v):
  - existing TYPE1..TYPE7 macros;
  - state codes SPAWN_IDLE, SPAWN_LOAD, SPAWN_CHECK, SPAWN_PLAY, SPAWN_OVER (3-bit);
  - default DROP_PERIOD.
- Sub-module drop_timer:
  - inputs: clock, reset, enable, clear, `soft_drop`;
  - output: `drop_tick`;
  - parameters: DROP_PERIOD and SOFT_DIV.
- spawn_ctrl holds the FSM and the `cur_type` register.

Test Plan:
- Reset, then pulse `key_start`, with `next_type`=5: `Update` high exactly 1 cycle; the next cycle `cur_type`=5 and `spawn_req`=1.
- In CHECK, hold `check_ack`=0 for 10 cycles, then `check_ack`=1 with `spawn_blocked`=0: `spawn_req` stays high 10 cycles; `spawn_valid` pulses once; `playing`=1.
- PLAY with DROP_PERIOD=16 and `soft_drop`=0: `drop_tick` every 16 cycles. With `soft_drop`=1 and SOFT_DIV=8: tick every 2 cycles.
- Assert `piece_locked` on the cycle the counter reaches T: no `drop_tick`; LOAD follows with one `Update` pulse; `cur_type` takes the current `next_type`.
- Spawn check answered with `spawn_blocked`=1: `game_over`=1 and `playing`=0. `key_start` and `piece_locked` then cause no change until `key_reset`.
- Assert `key_reset` asynchronously mid-CHECK and mid-PLAY: all outputs 0 immediately, state IDLE; `key_start` afterwards restarts normally.
